// File: rtl/product_accumulator_if.sv
// ----------------------------------------------------------------------------
// product_accumulator_if
//
// Bundles the two handshakes of the product accumulator.
//   Input side  : in_valid/in_ready carry one unsigned product (in_prod) per
//                 beat; in_last marks the final beat of a block.
//   Output side : out_valid/out_ready carry one block result (out_sum,
//                 out_count, out_ovf).
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. The sender holds its payload and valid
// stable until that edge. ready may be asserted before valid.
//
// Modports
//   master : the producer/consumer side (drives in_*, out_ready)
//   slave  : the accumulator (drives in_ready, out_*)
// ----------------------------------------------------------------------------
interface product_accumulator_if #(
    parameter int PW  = 16,
    parameter int AW  = 24,
    parameter int LEN = 4
);
    localparam int CW = $clog2(LEN + 1);

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          in_last;

    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
//
// Sums blocks of up to LEN unsigned PW-bit products into an AW-bit
// accumulator and presents each block total on a held output handshake.
// A block ends on an accepted beat with in_last=1 or on the LEN-th beat.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   rst         : asynchronous active-high reset
//   clr         : synchronous block abort (ignored while a result is held)
//   bus         : product_accumulator_if.slave (input and output handshakes)
//   dbg_state_o : current FSM state (0 = ACC, 1 = HOLD)
//
// Configuration macro
//   PRODUCT_ACC_SAT_EN : when defined the accumulator saturates at 2^AW-1 on
//                        overflow; otherwise it wraps modulo 2^AW. out_ovf
//                        reports the overflow in both builds.
// ----------------------------------------------------------------------------
module product_accumulator #(
    parameter int PW  = 16,
    parameter int AW  = 24,
    parameter int LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    product_accumulator_if.slave   bus,
    output logic                   dbg_state_o
);
    localparam int CW = $clog2(LEN + 1);

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_q;
    logic [AW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;

    logic          out_valid_q;
    logic [AW-1:0] out_sum_q;
    logic [CW-1:0] out_count_q;
    logic          out_ovf_q;

    logic [AW-1:0] acc_d;
    logic [CW-1:0] cnt_d;
    logic          ovf_d;
    logic [AW:0]   sum_w;
    logic          carry;
    logic          in_fire;
    logic          last_beat;

    // Ready depends on state and reset only, never on out_ready.
    assign bus.in_ready  = (state_q == ACC) && !rst;
    assign in_fire       = bus.in_valid && bus.in_ready;

    // One extra bit catches the carry out of the accumulator.
    assign sum_w = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, bus.in_prod};
    assign carry = sum_w[AW];

    always_comb begin
        acc_d = sum_w[AW-1:0];
`ifdef PRODUCT_ACC_SAT_EN
        // Once clamped the accumulator stays at full scale for the block.
        if (carry || ovf_q) begin
            acc_d = {AW{1'b1}};
        end
`endif
        ovf_d = ovf_q | carry;
        cnt_d = cnt_q + CW'(1);
    end

    assign last_beat = bus.in_last || (cnt_q == CW'(LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (clr) begin
                        // Abort wins over a beat offered in the same cycle.
                        acc_q <= '0;
                        cnt_q <= '0;
                        ovf_q <= 1'b0;
                    end else if (in_fire) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        if (last_beat) begin
                            out_sum_q   <= acc_d;
                            out_count_q <= cnt_d;
                            out_ovf_q   <= ovf_d;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // clr is deliberately ignored here: a held result is
                    // only released by the consumer.
                    if (bus.out_ready) begin
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        state_q     <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_product_accumulator.sv
// ----------------------------------------------------------------------------
// tb_product_accumulator
//
// Drives two accumulators: dut_a with the default widths (AW=24) and dut_b
// with AW=17 for the overflow scenario. Inputs change 1 ns after the rising
// edge; the result monitor samples on the falling edge.
// ----------------------------------------------------------------------------
module tb_product_accumulator;
    localparam int PW   = 16;
    localparam int LEN  = 4;
    localparam int AW_A = 24;
    localparam int AW_B = 17;
    localparam int CW   = $clog2(LEN + 1);
    localparam int W    = AW_A + CW + 1;

    logic clk;
    logic rst;
    logic clr_a;
    logic clr_b;
    logic dbg_a;
    logic dbg_b;

    int tests_run = 0;
    int failures  = 0;

    // Expected results of dut_a: {sum, count, ovf}
    logic [W-1:0] exp_q[$];
    longint       blk_sum;
    int           blk_cnt;

    product_accumulator_if #(.PW(PW), .AW(AW_A), .LEN(LEN)) a_if ();
    product_accumulator_if #(.PW(PW), .AW(AW_B), .LEN(LEN)) b_if ();

    product_accumulator #(.PW(PW), .AW(AW_A), .LEN(LEN)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr_a),
        .bus         (a_if.slave),
        .dbg_state_o (dbg_a)
    );

    product_accumulator #(.PW(PW), .AW(AW_B), .LEN(LEN)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr_b),
        .bus         (b_if.slave),
        .dbg_state_o (dbg_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Block result from plain arithmetic: total of the block's products,
    // then clamped or reduced modulo 2^aw.
    function automatic longint model_sum(input longint total, input int aw);
        longint maxv;
        maxv = (longint'(1) << aw) - 1;
`ifdef PRODUCT_ACC_SAT_EN
        return (total > maxv) ? maxv : total;
`else
        return total % (maxv + 1);
`endif
    endfunction

    task automatic model_clear();
        blk_sum = 0;
        blk_cnt = 0;
    endtask

    task automatic model_beat(input logic [PW-1:0] prod, input logic last);
        logic [AW_A-1:0] s;
        logic [CW-1:0]   c;
        logic            o;
        blk_sum += prod;
        blk_cnt++;
        if (last || blk_cnt == LEN) begin
            s = AW_A'(model_sum(blk_sum, AW_A));
            c = CW'(blk_cnt);
            o = (blk_sum > ((longint'(1) << AW_A) - 1));
            exp_q.push_back({s, c, o});
            model_clear();
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [PW-1:0] prod, input logic last);
        bit done;
        int budget;
        done   = 0;
        budget = 0;
        a_if.in_valid = 1'b1;
        a_if.in_prod  = prod;
        a_if.in_last  = last;
        while (!done && budget < 50) begin
            if (a_if.in_ready && !clr_a) begin
                model_beat(prod, last);
                done = 1;
            end
            tick();
            budget++;
        end
        a_if.in_valid = 1'b0;
        a_if.in_last  = 1'b0;
        tests_run++;
        if (!done) begin
            failures++;
            $display("FAIL send_timeout: beat 0x%04h not accepted, got in_ready=%0b want 1", prod, a_if.in_ready);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        if (!rst && a_if.out_valid && a_if.out_ready) begin
            got = {a_if.out_sum, a_if.out_count, a_if.out_ovf};
            tests_run++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got sum=0x%06h cnt=%0d ovf=%0b, want no result",
                         a_if.out_sum, a_if.out_count, a_if.out_ovf);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL sb_result: got {sum,cnt,ovf}=0x%07h want 0x%07h", got, exp);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        #12;
        tests_run++;
        if (a_if.out_valid !== 1'b0 || a_if.out_sum !== '0 || a_if.out_count !== '0 || a_if.out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%0b sum=0x%06h cnt=%0d ovf=%0b want all 0",
                     a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf);
        end
        tests_run++;
        if (a_if.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %0b want 0", a_if.in_ready);
        end
        rst = 1'b0;
        model_clear();
        tick();
        tests_run++;
        if (a_if.in_ready !== 1'b1 || dbg_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got in_ready=%0b state=%0b want 1/0", a_if.in_ready, dbg_a);
        end
    endtask

    task automatic test_full_block();
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(16'h0010, 1'b0);
        tests_run++;
        if (a_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_early: got out_valid=%0b want 0 after 3 beats", a_if.out_valid);
        end
        send(16'h0010, 1'b0);
        tests_run++;
        if (a_if.out_valid !== 1'b1 || a_if.out_sum !== 24'h000040 || a_if.out_count !== 3'd4 || a_if.out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL full_result: got v=%0b sum=0x%06h cnt=%0d ovf=%0b want 1/0x000040/4/0",
                     a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf);
        end
        tick();
        tests_run++;
        if (a_if.in_ready !== 1'b1 || a_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_return: got in_ready=%0b out_valid=%0b want 1/0", a_if.in_ready, a_if.out_valid);
        end
    endtask

    task automatic test_backpressure();
        a_if.out_ready = 1'b0;
        send(16'h0003, 1'b0);
        send(16'h0005, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (a_if.out_valid !== 1'b1 || a_if.out_sum !== 24'h000008 || a_if.out_count !== 3'd2 || a_if.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got v=%0b sum=0x%06h cnt=%0d rdy=%0b want 1/0x000008/2/0",
                         i, a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.in_ready);
            end
            clr_a = (i == 2); // abort must not disturb a held result
            tick();
        end
        clr_a = 1'b0;
        a_if.out_ready = 1'b1;
        tick();
        tests_run++;
        if (a_if.out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_single_transfer: got out_valid=%0b pending=%0d want 0/0", a_if.out_valid, exp_q.size());
        end
    endtask

    task automatic test_clr();
        a_if.out_ready = 1'b1;
        send(16'h0100, 1'b0);
        send(16'h0200, 1'b0);
        clr_a = 1'b1;
        a_if.in_valid = 1'b1;
        a_if.in_prod  = 16'h0400;
        model_clear();
        tick();
        clr_a = 1'b0;
        a_if.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) send(16'h0001, 1'b0);
        tests_run++;
        if (a_if.out_valid !== 1'b1 || a_if.out_sum !== 24'h000004 || a_if.out_count !== 3'd4 || a_if.out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL clr_result: got v=%0b sum=0x%06h cnt=%0d ovf=%0b want 1/0x000004/4/0",
                     a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.out_ovf);
        end
        tick();
    endtask

    task automatic test_overflow();
        longint total;
        logic [AW_B-1:0] exp_sum;
        int budget;
        int beats;
        total  = 0;
        beats  = 0;
        budget = 0;
        b_if.out_ready = 1'b0;
        b_if.in_prod   = 16'hFFFF;
        b_if.in_last   = 1'b0;
        b_if.in_valid  = 1'b1;
        while (beats < 4 && budget < 20) begin
            if (b_if.in_ready) begin
                beats++;
                total += 16'hFFFF;
            end
            tick();
            budget++;
        end
        b_if.in_valid = 1'b0;
        exp_sum = AW_B'(model_sum(total, AW_B));
        tests_run++;
        if (b_if.out_valid !== 1'b1 || b_if.out_sum !== exp_sum || b_if.out_ovf !== 1'b1 || b_if.out_count !== 3'd4) begin
            failures++;
            $display("FAIL ovf_result: got v=%0b sum=0x%05h cnt=%0d ovf=%0b want 1/0x%05h/4/1",
                     b_if.out_valid, b_if.out_sum, b_if.out_count, b_if.out_ovf, exp_sum);
        end
        b_if.out_ready = 1'b1;
        tick();
        // Next block must start with the sticky flag cleared.
        b_if.in_prod  = 16'h0001;
        b_if.in_valid = 1'b1;
        tick();
        b_if.in_last  = 1'b1;
        tick();
        b_if.in_valid = 1'b0;
        b_if.in_last  = 1'b0;
        b_if.out_ready = 1'b0;
        tests_run++;
        if (b_if.out_valid !== 1'b1 || b_if.out_sum !== 17'h00002 || b_if.out_count !== 3'd2 || b_if.out_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_next_block: got v=%0b sum=0x%05h cnt=%0d ovf=%0b want 1/0x00002/2/0",
                     b_if.out_valid, b_if.out_sum, b_if.out_count, b_if.out_ovf);
        end
        b_if.out_ready = 1'b1;
        tick();
    endtask

    task automatic reset_pulse(input string tag);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (a_if.out_valid !== 1'b0 || a_if.out_sum !== '0 || a_if.out_count !== '0 || a_if.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s: got v=%0b sum=0x%06h cnt=%0d rdy=%0b want 0/0/0/0",
                     tag, a_if.out_valid, a_if.out_sum, a_if.out_count, a_if.in_ready);
        end
        model_clear();
        exp_q.delete();
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        a_if.out_ready = 1'b0;
        send(16'h0002, 1'b0);
        send(16'h0002, 1'b0);
        reset_pulse("rst_mid_block");
        for (int i = 0; i < 4; i++) send(16'h0005, 1'b0);
        tests_run++;
        if (a_if.out_valid !== 1'b1 || a_if.out_sum !== 24'h000014) begin
            failures++;
            $display("FAIL rst_hold_setup: got v=%0b sum=0x%06h want 1/0x000014", a_if.out_valid, a_if.out_sum);
        end
        reset_pulse("rst_in_hold");
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h0002, 1'b0);
        tests_run++;
        if (a_if.out_sum !== 24'h000008 || a_if.out_count !== 3'd4) begin
            failures++;
            $display("FAIL rst_after: got sum=0x%06h cnt=%0d want 0x000008/4", a_if.out_sum, a_if.out_count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int accepted;
        int hs;
        int last_hs;
        int bad_gap;
        accepted = 0;
        hs       = 0;
        last_hs  = -1;
        bad_gap  = 0;
        a_if.out_ready = 1'b1;
        a_if.in_prod   = 16'h0001;
        a_if.in_last   = 1'b0;
        a_if.in_valid  = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (a_if.in_ready) begin
                accepted++;
                model_beat(16'h0001, 1'b0);
            end
            if (a_if.out_valid && a_if.out_ready) begin
                if (last_hs >= 0 && c - last_hs != 5) bad_gap++;
                last_hs = c;
                hs++;
            end
            tick();
        end
        a_if.in_valid = 1'b0;
        tests_run++;
        if (accepted != 12 || hs != 3 || bad_gap != 0) begin
            failures++;
            $display("FAIL stream: got beats=%0d results=%0d bad_gaps=%0d want 12/3/0", accepted, hs, bad_gap);
        end
    endtask

    task automatic test_random();
        int n;
        logic [PW-1:0] p;
        logic l;
        a_if.out_ready = 1'b1;
        for (int b = 0; b < 20; b++) begin
            n = $urandom_range(1, LEN);
            for (int i = 0; i < n; i++) begin
                p = PW'($urandom);
                l = (i == n - 1) && ($urandom_range(0, 1) == 1);
                send(p, l);
            end
            a_if.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            a_if.out_ready = 1'b1;
        end
        for (int i = 0; i < 6; i++) send(16'h0007, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (a_if.out_valid !== 1'b0 && exp_q.size() == 0) begin
            failures++;
            $display("FAIL random_drain: got out_valid=%0b with nothing pending", a_if.out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        clr_a = 1'b0;
        clr_b = 1'b0;
        a_if.in_valid = 1'b0; a_if.in_prod = '0; a_if.in_last = 1'b0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_prod = '0; b_if.in_last = 1'b0; b_if.out_ready = 1'b0;
        model_clear();
        test_reset();
        test_full_block();
        test_backpressure();
        test_clr();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        // Drain any partial block so the final queue check is exact.
        a_if.out_ready = 1'b1;
        for (int i = 0; i < LEN; i++) send(16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        tests_run++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d results not produced, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream stage of the 8x8 shift-and-add multiplier. Consumes unsigned 16-bit products over a valid/ready handshake and sums a block of up to LEN products into a wider accumulator. Presents the block total, beat count and overflow flag on a held output handshake. Blocks are LEN products long, or shorter when the producer terminates them with `in_last`.

## Interface
- `PW`, 16: product width; matches multiplier output m+n.
- `AW`, 24: accumulator/result width; must be ≥ PW.
- `LEN`, 4: maximum products per block; must be ≥ 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clr`  in  1  synchronous block abort; discards the partial sum.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  accumulator accepts a beat this cycle.
- `in_prod`  in  PW  unsigned product.
- `in_last`  in  1  final beat of the block; qualified by the handshake.
- `out_valid`  out  1  block result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  AW  block total.
- `out_count`  out  $clog2(LEN+1)  number of beats summed, 1..LEN.
- `out_ovf`  out  1  result exceeded 2^AW−1 at some point in the block.

## Operation
- The FSM has two states, ACC and HOLD. Reset state is ACC.
- Internal registers:
  - `acc` (AW bits)
  - `cnt` ($clog2(LEN+1) bits)
  - `ovf` (1 bit, sticky within a block)
- ACC state:
  - `in_ready` = 1 (0 while `rst` high); `out_valid` = 0.
  - Beat accepted when `in_valid & in_ready`: `acc` ← `acc` + zero-extended `in_prod`; `cnt` ← `cnt` + 1.
  - Accepted beat with `in_last`=1, or with `cnt` == LEN−1: load `out_sum`/`out_count`/`out_ovf` from the post-add values and go to HOLD.
- HOLD state:
  - `in_ready` = 0; `out_valid` = 1; outputs held stable until accepted.
  - On `out_ready`=1: clear `acc`, `cnt` and `ovf`; return to ACC.
- Arithmetic: the sum is computed AW+1 bits wide. A carry out of bit AW−1 sets `ovf`. Result handling on overflow depends on the configuration macro.
- `clr`:
  - In ACC: zero `acc`, `cnt` and `ovf`; the beat offered that cycle is dropped. `clr` takes priority over a simultaneous handshake.
  - In HOLD: no effect. A pending result is never discarded.
- `in_last` on a beat that is not accepted is ignored.
- `in_prod` = 0 is a valid beat and counts.

## Timing
- Reset values:
  - `out_valid` = 0, `out_sum` = 0, `out_count` = 0, `out_ovf` = 0.
  - `in_ready` = 0 while `rst` is asserted, then 1 (ACC).
  - `acc`, `cnt` and `ovf` are cleared.
- `rst` mid-block or in HOLD: the partial sum or pending result is lost immediately. No output beat is produced.
- Latency: `out_valid` rises on the clock edge that accepts the final beat, i.e. the result is visible the next cycle.
- Throughput: at most one beat per cycle in ACC. Each block costs at least one extra cycle (HOLD), so the minimum is LEN+1 cycles per full block.
- `out_*` are registered. `in_ready` is decoded from state and `rst` only, with no combinational path from `out_ready`.
- `out_ready` asserted before `out_valid` is harmless. The handshake completes on the first HOLD cycle.

## Configuration
- `PRODUCT_ACC_SAT_EN` defined: on overflow, `acc` clamps to 2^AW−1 and stays clamped for the rest of the block; `out_ovf` = 1.
- `PRODUCT_ACC_SAT_EN` undefined: `acc` wraps modulo 2^AW; `out_ovf` = 1 still reports the wrap.

## Test plan
- Full block: defaults; four beats of 0x0010, no `in_last`, `out_ready`=1 → one cycle after the 4th beat, `out_valid`=1, `out_sum`=0x000040, `out_count`=4, `out_ovf`=0. Then `in_ready`=1 on the next cycle.
- Early termination and backpressure:
  - Stimulus: beats 0x0003 then 0x0005 (`in_last`=1); `out_ready`=0 for 5 cycles.
  - Required response: `out_sum`=0x000008 and `out_count`=2, held stable for all 5 cycles. `in_ready`=0 throughout. A single transfer occurs when `out_ready` rises.
- Overflow, AW=17, four beats of 0xFFFF:
  - With `PRODUCT_ACC_SAT_EN`: `out_sum`=0x1FFFF, `out_ovf`=1.
  - Without: `out_sum`=0x1FFFC, `out_ovf`=1.
- `clr` collision: beats 0x0100, 0x0200, then `clr`=1 together with a valid beat 0x0400, then four beats of 0x0001 → `out_sum`=0x000004, `out_count`=4. The next block starts with `out_ovf`=0.
- Reset mid-operation:
  - Stimulus: assert `rst` asynchronously after two beats, and again while in HOLD.
  - Required response: outputs return to 0 immediately and `in_ready`=0 during reset. After release, the next four 0x0002 beats give `out_sum`=0x000008.
- Streaming: `in_valid` and `out_ready` held high for 3 blocks of 0x0001 → results every 5 cycles, each `out_sum`=4 and `out_count`=4, with no lost or duplicated beats.
